// File: rtl/sigmoid_pkg.sv
// Shared constants and arithmetic helpers for the piecewise-linear sigmoid pipeline.
// Helpers work on 32-bit signed values; callers sign-extend in and slice out.
package sigmoid_pkg;

    localparam int unsigned PKG_FRAC = 12;
    localparam int unsigned PKG_ONE  = 32'd1 << PKG_FRAC;

    // Clamp v into [0, hi].
    function automatic logic signed [31:0] sat_clamp(
        input logic signed [31:0] v,
        input logic signed [31:0] hi
    );
        logic signed [31:0] res;
        if (v < 32'sd0) begin
            res = 32'sd0;
        end else if (v > hi) begin
            res = hi;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // |v|, with the most negative representable value (min_v) mapped to -min_v - 1.
    function automatic logic signed [31:0] abs_sat(
        input logic signed [31:0] v,
        input logic signed [31:0] min_v
    );
        logic signed [31:0] res;
        if (v == min_v) begin
            res = -(v + 32'sd1);
        end else if (v < 32'sd0) begin
            res = -v;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/sigmoid_pla_pipe_coef_bank.sv
// NSEG-entry gradient/offset register file: one write port, one combinational read port.
// A read in the same cycle as a write to the same entry returns the old value.
module pla_coef_bank
    import sigmoid_pkg::*;
#(
    parameter int BITS = 16,
    parameter int NSEG = 4,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [BITS-1:0] i_grad,
    input  logic [BITS-1:0] i_off,
    input  logic [AW-1:0]   i_raddr,
    output logic [BITS-1:0] o_grad,
    output logic [BITS-1:0] o_off
);

    logic [BITS-1:0] r_grad [NSEG];
    logic [BITS-1:0] r_off  [NSEG];
    logic            w_wr_ok;
    logic            w_rd_ok;

    assign w_wr_ok = i_we && ({{(32-AW){1'b0}}, i_waddr} < 32'(NSEG));
    assign w_rd_ok = {{(32-AW){1'b0}}, i_raddr} < 32'(NSEG);

    // Coefficient storage; writes to nonexistent entries are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                r_grad[i] <= '0;
                r_off[i]  <= '0;
            end
        end else if (w_wr_ok) begin
            r_grad[i_waddr] <= i_grad;
            r_off[i_waddr]  <= i_off;
        end
    end

    always_comb begin
        o_grad = '0;
        o_off  = '0;
        if (w_rd_ok) begin
            o_grad = r_grad[i_raddr];
            o_off  = r_off[i_raddr];
        end else begin
            o_grad = '0;
            o_off  = '0;
        end
    end

endmodule

// File: rtl/sigmoid_pla_pipe.sv
// Three-stage piecewise-linear sigmoid: segment select on |x|, multiply, offset/clamp/mirror.
// All stages advance together; a stalled output freezes the whole pipe.
module sigmoid_pla_pipe
    import sigmoid_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int FRAC      = int'(PKG_FRAC),
    parameter int NSEG      = 4,
    parameter int SEG_SHIFT = 12,
    localparam int AW       = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] y,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [BITS-1:0] cfg_grad,
    input  logic [BITS-1:0] cfg_off
);

    localparam int PW = BITS + 2;
    localparam logic [BITS-1:0]   ONE_B  = {{(BITS-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [31:0] ONE_32 = 32'sd1 <<< FRAC;
    localparam logic signed [31:0] MIN_32 = -(32'sd1 <<< (BITS-1));

    logic w_adv;

    // Stage 1 combinational
    logic signed [31:0] w_x32;
    logic signed [31:0] w_abs32;
    logic [BITS-1:0]    w_a;
    logic [BITS-1:0]    w_idx;
    logic               w_sat;
    logic [AW-1:0]      w_raddr;
    logic [BITS-1:0]    w_grad;
    logic [BITS-1:0]    w_off;

    // Stage 1 registers
    logic            r_v1;
    logic            r_s1;
    logic            r_sat1;
    logic [BITS-1:0] r_a1;
    logic [BITS-1:0] r_g1;
    logic [BITS-1:0] r_o1;

    // Stage 2
    logic signed [BITS-1:0]   w_g1s;
    logic signed [BITS-1:0]   w_a1s;
    logic signed [2*BITS-1:0] w_prod;
    logic signed [2*BITS-1:0] w_psh;
    logic                     r_v2;
    logic                     r_s2;
    logic                     r_sat2;
    logic signed [PW-1:0]     r_p2;
    logic [BITS-1:0]          r_o2;

    // Stage 3
    logic signed [PW-1:0] w_v;
    logic signed [31:0]   w_v32;
    logic signed [31:0]   w_cl32;
    logic [BITS-1:0]      w_cl;
    logic [BITS-1:0]      w_vf;
    logic [BITS-1:0]      w_y;
    logic                 r_v3;
    logic [BITS-1:0]      r_y;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign y         = r_y;

    assign w_x32   = {{(32-BITS){x[BITS-1]}}, x};
    assign w_abs32 = abs_sat(w_x32, MIN_32);
    assign w_a     = w_abs32[BITS-1:0];
    assign w_idx   = w_a >> SEG_SHIFT;
    assign w_sat   = {{(32-BITS){1'b0}}, w_idx} >= 32'(NSEG);
    assign w_raddr = w_sat ? '0 : w_idx[AW-1:0];

    pla_coef_bank #(
        .BITS (BITS),
        .NSEG (NSEG),
        .AW   (AW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_grad  (cfg_grad),
        .i_off   (cfg_off),
        .i_raddr (w_raddr),
        .o_grad  (w_grad),
        .o_off   (w_off)
    );

    // Both operands are signed BITS wide, so the product is the exact 2*BITS result.
    assign w_g1s  = r_g1;
    assign w_a1s  = r_a1;
    assign w_prod = w_g1s * w_a1s;
    assign w_psh  = w_prod >>> FRAC;

    assign w_v    = r_p2 + {{2{r_o2[BITS-1]}}, r_o2};
    assign w_v32  = {{(32-PW){w_v[PW-1]}}, w_v};
    assign w_cl32 = sat_clamp(w_v32, ONE_32);
    assign w_cl   = w_cl32[BITS-1:0];

    always_comb begin
        w_vf = '0;
        w_y  = '0;
        if (r_sat2) begin
            w_vf = ONE_B;
        end else begin
            w_vf = w_cl;
        end
        if (r_s2) begin
            w_y = ONE_B - w_vf;
        end else begin
            w_y = w_vf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_s1   <= 1'b0;
            r_sat1 <= 1'b0;
            r_a1   <= '0;
            r_g1   <= '0;
            r_o1   <= '0;
            r_v2   <= 1'b0;
            r_s2   <= 1'b0;
            r_sat2 <= 1'b0;
            r_p2   <= '0;
            r_o2   <= '0;
            r_v3   <= 1'b0;
            r_y    <= '0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_s1   <= x[BITS-1];
            r_sat1 <= w_sat;
            r_a1   <= w_a;
            r_g1   <= w_grad;
            r_o1   <= w_off;
            r_v2   <= r_v1;
            r_s2   <= r_s1;
            r_sat2 <= r_sat1;
            r_p2   <= w_psh[PW-1:0];
            r_o2   <= r_o1;
            r_v3   <= r_v2;
            // y keeps its last value across bubbles
            if (r_v2) begin
                r_y <= w_y;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_pla_pipe.sv
// Directed-vector bench for sigmoid_pla_pipe: latency, saturation, clamp, backpressure,
// coefficient write during traffic and mid-stream reset.
module tb_sigmoid_pla_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_grad;
    logic [15:0] cfg_off;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] vin  [8];
    logic [15:0] vexp [8];
    int          nv;

    always #5 clk = ~clk;

    sigmoid_pla_pipe #(
        .BITS      (16),
        .FRAC      (12),
        .NSEG      (4),
        .SEG_SHIFT (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_grad  (cfg_grad),
        .cfg_off   (cfg_off)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] g, input logic [15:0] o);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_grad = g;
        cfg_off  = o;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // mode 0: out_ready held high, latency checked; mode 1: out_ready pattern 1,0,0,1 repeating.
    // wr_first: write seg0 {0x0400, 0x0000} in the first stream cycle.
    task automatic run_stream(input string tag, input int mode, input bit wr_first);
        int          in_i   = 0;
        int          out_i  = 0;
        int          cyc    = 0;
        int          acc_cyc [8];
        logic        held_v = 1'b0;
        logic [15:0] held_y = 16'h0000;
        while (out_i < nv && cyc < 200) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_valid  = (in_i < nv);
            x         = (in_i < nv) ? vin[in_i] : 16'h0000;
            if (wr_first && cyc == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'd0;
                cfg_grad = 16'h0400;
                cfg_off  = 16'h0000;
            end else begin
                cfg_we   = 1'b0;
            end
            #1;
            if (mode == 1) begin
                check({tag, ".in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
            end
            if (held_v) begin
                check({tag, ".stall_y"}, 32'(y), 32'(held_y));
            end
            if (out_valid && out_ready) begin
                check({tag, ".y"}, 32'(y), 32'(vexp[out_i]));
                if (mode == 0) begin
                    check({tag, ".lat"}, 32'(cyc - acc_cyc[out_i]), 32'd3);
                end
                out_i++;
            end
            held_v = out_valid && !out_ready;
            held_y = y;
            if (in_valid && in_ready) begin
                acc_cyc[in_i] = cyc;
                in_i++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        if (out_i != nv) begin
            check({tag, ".timeout"}, 32'(out_i), 32'(nv));
        end
    endtask

    task automatic single(input string tag, input logic [15:0] xi, input logic [15:0] ye);
        nv      = 1;
        vin[0]  = xi;
        vexp[0] = ye;
        run_stream(tag, 0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = 16'h0000;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_grad  = 16'h0000;
        cfg_off   = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.y", 32'(y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        cfg_write(2'd0, 16'h0400, 16'h0800);

        single("t1.x0000", 16'h0000, 16'h0800);
        single("t1.x0800", 16'h0800, 16'h0A00);
        single("t1.xF800", 16'hF800, 16'h0600);

        single("t2.x5000", 16'h5000, 16'h1000);
        single("t2.xB000", 16'hB000, 16'h0000);
        single("t2.x8000", 16'h8000, 16'h0000);

        cfg_write(2'd1, 16'h1000, 16'h1000);
        single("t3.x1800", 16'h1800, 16'h1000);
        single("t3.xE800", 16'hE800, 16'h0000);

        nv = 8;
        vin[0] = 16'h0000; vexp[0] = 16'h0800;
        vin[1] = 16'h0800; vexp[1] = 16'h0A00;
        vin[2] = 16'hF800; vexp[2] = 16'h0600;
        vin[3] = 16'h0400; vexp[3] = 16'h0900;
        vin[4] = 16'hFC00; vexp[4] = 16'h0700;
        vin[5] = 16'h5000; vexp[5] = 16'h1000;
        vin[6] = 16'h1800; vexp[6] = 16'h1000;
        vin[7] = 16'hE800; vexp[7] = 16'h0000;
        run_stream("t4", 1, 1'b0);

        nv = 2;
        vin[0] = 16'h0800; vexp[0] = 16'h0A00;
        vin[1] = 16'h0800; vexp[1] = 16'h0200;
        run_stream("t5", 0, 1'b1);

        // Three samples enter while the output is blocked, then reset lands.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 16'h0800;
        @(negedge clk);
        x         = 16'h0000;
        @(negedge clk);
        x         = 16'hF800;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check("t6.pre_valid", 32'(out_valid), 32'd1);
        check("t6.pre_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6.post_valid", 32'(out_valid), 32'd0);
        check("t6.post_y", 32'(y), 32'd0);
        check("t6.post_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6.no_out", 32'(out_valid), 32'd0);
        end
        single("t6.coef0", 16'h0800, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
